timer_ctrl: RTL and testbench



---
 rtl/timer_ctrl.sv | 161 ++++++++++++++++
 tb/tb_timer_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : timer_ctrl
// Purpose  : Control stage in front of a loadable N-bit up-counter. Adds a
//            prescaler, a compare match and one-shot / periodic modes, so the
//            bare counter behaves as a programmable timer.
// Ports    : clk, arst_n          - clock, asynchronous active-low reset
//            start_i, stop_i      - start / abort requests (sampled each cycle)
//            mode_i               - 0 one-shot, 1 periodic (captured on start)
//            prescale_i           - enable divider PS (captured on start)
//            start_val_i          - counter start value S (captured on start)
//            compare_val_i        - compare value C (captured on start)
//            cnt_i                - live count from the downstream counter
//            cnt_load_o/_val_o    - load strobe and load value to the counter
//            cnt_en_o             - count enable to the counter
//            busy_o, done_o       - status (LOAD/RUN, one-shot complete)
//            match_o              - one-cycle pulse after each terminal event
// Revision : 1.0 - initial release
// ============================================================================
module timer_ctrl #(
    parameter int N = 4,
    parameter int P = 8
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         start_i,
    input  logic         stop_i,
    input  logic         mode_i,
    input  logic [P-1:0] prescale_i,
    input  logic [N-1:0] start_val_i,
    input  logic [N-1:0] compare_val_i,
    input  logic [N-1:0] cnt_i,
    output logic         cnt_load_o,
    output logic [N-1:0] cnt_load_val_o,
    output logic         cnt_en_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         match_o
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_RUN  = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    localparam logic [P-1:0] c_PRE_ONE = {{(P-1){1'b0}}, 1'b1};

    logic [1:0]   state_q, state_d;
    logic         mode_q;
    logic [P-1:0] ps_q;
    logic [N-1:0] s_q;
    logic [N-1:0] c_q;
    logic [P-1:0] pre_q, pre_d;
    logic         match_q, match_d;

    logic w_run;
    logic w_ripe;
    logic w_at_cmp;
    logic w_terminal;
    logic w_accept;

    // Ripe marks the one cycle in PS+1 on which the counter may advance.
    // The terminal event reuses the same slot, so the final count C is
    // observed for a full prescale period before the match fires.
    always_comb begin
        w_run      = (state_q == c_ST_RUN);
        w_ripe     = (pre_q == ps_q);
        w_at_cmp   = (cnt_i == c_q);
        w_terminal = w_run & w_ripe & w_at_cmp;
        w_accept   = start_i & ~stop_i &
                     ((state_q == c_ST_IDLE) | (state_q == c_ST_DONE));
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; stop has priority over start and terminal events
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: begin
                if (w_accept) state_d = c_ST_LOAD;
            end
            c_ST_LOAD: begin
                if (stop_i) state_d = c_ST_IDLE;
                else        state_d = c_ST_RUN;
            end
            c_ST_RUN: begin
                if (stop_i)          state_d = c_ST_IDLE;
                else if (w_terminal) state_d = mode_q ? c_ST_LOAD : c_ST_DONE;
            end
            c_ST_DONE: begin
                if (stop_i)        state_d = c_ST_IDLE;
                else if (w_accept) state_d = c_ST_LOAD;
            end
            default: state_d = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        cnt_load_o = (state_q == c_ST_LOAD);
        busy_o     = (state_q == c_ST_LOAD) | (state_q == c_ST_RUN);
        done_o     = (state_q == c_ST_DONE);
        // Withheld on the terminal cycle so the counter parks on C.
        cnt_en_o   = w_run & w_ripe & ~w_at_cmp;
    end

    assign cnt_load_val_o = s_q;
    assign match_o        = match_q;

    // ------------------------------------------------------------------
    // Prescaler and match pulse next-state
    // ------------------------------------------------------------------
    always_comb begin
        pre_d = pre_q;
        if (state_q == c_ST_LOAD) begin
            pre_d = '0;
        end else if (w_run) begin
            pre_d = w_ripe ? '0 : (pre_q + c_PRE_ONE);
        end
        match_d = w_terminal & ~stop_i;
    end

    // ------------------------------------------------------------------
    // Shadow registers, prescaler, match register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            mode_q  <= 1'b0;
            ps_q    <= '0;
            s_q     <= '0;
            c_q     <= '0;
            pre_q   <= '0;
            match_q <= 1'b0;
        end else begin
            if (w_accept) begin
                mode_q <= mode_i;
                ps_q   <= prescale_i;
                s_q    <= start_val_i;
                c_q    <= compare_val_i;
            end
            pre_q   <= pre_d;
            match_q <= match_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_ctrl
// Purpose  : Self-checking bench for timer_ctrl. Contains a model of the
//            downstream loadable counter and a timeline reference model that
//            predicts the outputs for every cycle after an accepted start.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_ctrl;

    localparam int N = 4;
    localparam int P = 8;
    localparam int M = 1 << N;

    logic         clk = 1'b0;
    logic         arst_n = 1'b0;
    logic         start_i = 1'b0;
    logic         stop_i = 1'b0;
    logic         mode_i = 1'b0;
    logic [P-1:0] prescale_i = '0;
    logic [N-1:0] start_val_i = '0;
    logic [N-1:0] compare_val_i = '0;
    logic [N-1:0] cnt;
    logic         cnt_load_o;
    logic [N-1:0] cnt_load_val_o;
    logic         cnt_en_o;
    logic         busy_o;
    logic         done_o;
    logic         match_o;

    int checks = 0;
    int errors = 0;

    timer_ctrl #(.N(N), .P(P)) dut (
        .clk            (clk),
        .arst_n         (arst_n),
        .start_i        (start_i),
        .stop_i         (stop_i),
        .mode_i         (mode_i),
        .prescale_i     (prescale_i),
        .start_val_i    (start_val_i),
        .compare_val_i  (compare_val_i),
        .cnt_i          (cnt),
        .cnt_load_o     (cnt_load_o),
        .cnt_load_val_o (cnt_load_val_o),
        .cnt_en_o       (cnt_en_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .match_o        (match_o)
    );

    always #5 clk = ~clk;

    // Downstream loadable up-counter.
    always @(posedge clk or negedge arst_n) begin
        if (!arst_n)         cnt <= '0;
        else if (cnt_load_o) cnt <= cnt_load_val_o;
        else if (cnt_en_o)   cnt <= cnt + 1'b1;
    end

    // Observed outputs packed as {load, en, busy, done, match}.
    function automatic logic [4:0] obs();
        return {cnt_load_o, cnt_en_o, busy_o, done_o, match_o};
    endfunction

    // RUN cycles until terminal: (D+1)*(PS+1), D = (C-S) mod 2^N.
    function automatic int term_cycle(int s, int c, int ps);
        return (((c - s + M) % M) + 1) * (ps + 1);
    endfunction

    // Expected outputs k cycles after the start was accepted (k=0 is LOAD).
    function automatic logic [4:0] model(int k, int s, int c, int ps, bit per);
        int  t, j;
        logic ld, en, bz, dn, mt;
        t  = term_cycle(s, c, ps);
        ld = 1'b0; en = 1'b0; bz = 1'b0; dn = 1'b0; mt = 1'b0;
        if (per) begin
            j  = k % (t + 1);
            ld = (j == 0);
            bz = 1'b1;
            mt = (k > 0) && (j == 0);
            en = (j > 0) && (j < t) && ((j % (ps + 1)) == 0);
        end else begin
            ld = (k == 0);
            bz = (k <= t);
            en = (k >= 1) && (k < t) && ((k % (ps + 1)) == 0);
            dn = (k > t);
            mt = (k == t + 1);
        end
        return {ld, en, bz, dn, mt};
    endfunction

    // Stimulus only: presents a start for one cycle, then scrambles the
    // configuration inputs so that only the captured values can matter.
    task automatic drive_start(int s, int c, int ps, bit per);
        @(posedge clk); #1;
        start_i       = 1'b1;
        start_val_i   = N'(s);
        compare_val_i = N'(c);
        prescale_i    = P'(ps);
        mode_i        = per;
        @(posedge clk); #1;
        start_i       = 1'b0;
        start_val_i   = N'($urandom);
        compare_val_i = N'($urandom);
        prescale_i    = P'($urandom);
        mode_i        = 1'($urandom);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (obs() !== 5'b0 || cnt_load_val_o !== '0) begin
            errors++;
            $display("FAIL reset_held got=%b/%0d want=00000/0", obs(), cnt_load_val_o);
        end
        @(negedge clk);
        arst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (obs() !== 5'b0 || cnt_load_val_o !== '0) begin
                errors++;
                $display("FAIL reset_idle k=%0d got=%b/%0d want=00000/0", k, obs(), cnt_load_val_o);
            end
        end
    endtask

    task automatic test_oneshot();
        drive_start(2, 5, 0, 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (obs() !== model(k, 2, 5, 0, 0) || cnt_load_val_o !== 4'd2) begin
                errors++;
                $display("FAIL oneshot k=%0d got=%b/%0d want=%b/2", k, obs(), cnt_load_val_o, model(k, 2, 5, 0, 0));
            end
        end
        checks++;
        if (cnt !== 4'd5) begin
            errors++;
            $display("FAIL oneshot_hold got=%0d want=5", cnt);
        end
    endtask

    task automatic test_start_in_done();
        drive_start(3, 4, 0, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (obs() !== model(k, 3, 4, 0, 0) || cnt_load_val_o !== 4'd3) begin
                errors++;
                $display("FAIL start_in_done k=%0d got=%b/%0d want=%b/3", k, obs(), cnt_load_val_o, model(k, 3, 4, 0, 0));
            end
        end
    endtask

    task automatic test_prescale();
        drive_start(0, 1, 2, 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (obs() !== model(k, 0, 1, 2, 0)) begin
                errors++;
                $display("FAIL prescale k=%0d got=%b want=%b", k, obs(), model(k, 0, 1, 2, 0));
            end
        end
    endtask

    // Periodic wrap 14,15,0,1 with an ignored start (S=7) injected mid-RUN.
    task automatic test_periodic();
        int j;
        logic [N-1:0] want_cnt;
        drive_start(14, 1, 0, 1);
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            checks++;
            if (obs() !== model(k, 14, 1, 0, 1) || cnt_load_val_o !== 4'd14) begin
                errors++;
                $display("FAIL periodic k=%0d got=%b/%0d want=%b/14", k, obs(), cnt_load_val_o, model(k, 14, 1, 0, 1));
            end
            j = k % 5;
            if (j != 0) begin
                want_cnt = N'(14 + j - 1);
                checks++;
                if (cnt !== want_cnt) begin
                    errors++;
                    $display("FAIL periodic_cnt k=%0d got=%0d want=%0d", k, cnt, want_cnt);
                end
            end
            if (k == 7) begin
                start_i       = 1'b1;
                start_val_i   = 4'd7;
                compare_val_i = 4'd9;
            end
        end
        stop_i = 1'b1;
        @(negedge clk);
        stop_i = 1'b0;
        checks++;
        if (obs() !== 5'b0) begin
            errors++;
            $display("FAIL periodic_stop got=%b want=00000", obs());
        end
    endtask

    // Stop in RUN cycle 2, then stop exactly on the terminal cycle.
    task automatic test_stop();
        int stop_k;
        logic [4:0] want;
        for (int r = 0; r < 2; r++) begin
            stop_k = (r == 0) ? 2 : 4;
            drive_start(2, 5, 0, 0);
            for (int k = 0; k < stop_k + 5; k++) begin
                @(negedge clk);
                stop_i = 1'b0;
                want = (k <= stop_k) ? model(k, 2, 5, 0, 0) : 5'b0;
                checks++;
                if (obs() !== want) begin
                    errors++;
                    $display("FAIL stop_at_%0d k=%0d got=%b want=%b", stop_k, k, obs(), want);
                end
                if (k == stop_k) stop_i = 1'b1;
            end
        end
    endtask

    task automatic test_random();
        int s, c, ps, t, ncyc;
        bit per;
        for (int it = 0; it < 12; it++) begin
            s   = $urandom_range(0, M - 1);
            c   = $urandom_range(0, M - 1);
            ps  = $urandom_range(0, 3);
            per = 1'($urandom);
            t   = term_cycle(s, c, ps);
            ncyc = per ? (2 * (t + 1) + 2) : (t + 4);
            drive_start(s, c, ps, per);
            for (int k = 0; k < ncyc; k++) begin
                @(negedge clk);
                checks++;
                if (obs() !== model(k, s, c, ps, per) || cnt_load_val_o !== N'(s)) begin
                    errors++;
                    $display("FAIL random it=%0d S=%0d C=%0d PS=%0d per=%0d k=%0d got=%b/%0d want=%b/%0d",
                             it, s, c, ps, per, k, obs(), cnt_load_val_o, model(k, s, c, ps, per), s);
                end
            end
            if (per || $urandom_range(0, 1) == 1) begin
                stop_i = 1'b1;
                @(negedge clk);
                stop_i = 1'b0;
                checks++;
                if (obs() !== 5'b0) begin
                    errors++;
                    $display("FAIL random_stop it=%0d got=%b want=00000", it, obs());
                end
            end
        end
    endtask

    task automatic test_reset_midrun();
        drive_start(2, 5, 2, 0);
        repeat (4) @(negedge clk);
        #2;
        arst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== 5'b0 || cnt_load_val_o !== '0) begin
            errors++;
            $display("FAIL reset_midrun got=%b/%0d want=00000/0", obs(), cnt_load_val_o);
        end
        @(negedge clk);
        #2;
        arst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (obs() !== 5'b0) begin
                errors++;
                $display("FAIL reset_release k=%0d got=%b want=00000", k, obs());
            end
        end
        drive_start(3, 4, 0, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (obs() !== model(k, 3, 4, 0, 0)) begin
                errors++;
                $display("FAIL reset_recover k=%0d got=%b want=%b", k, obs(), model(k, 3, 4, 0, 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_start_in_done();
        test_prescale();
        test_periodic();
        test_stop();
        test_random();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
